// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package serial_sub_pkg;

  // Controller states; the encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A ^ B ^ Bin, borrow when A < B + Bin.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference bit and borrow-out of a single-bit subtraction step.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~A & Bin) | (B & Bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin, one result bit per clock through a single full-subtractor cell.
// Latency: WIDTH SHIFT cycles after the accepting start edge, then a one-cycle done pulse.
// Backpressure: start is only sampled in IDLE; requests in SHIFT/DONE are dropped, abort cancels SHIFT.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  state_t           state;
  state_t           next_state;

  // Working registers: operands shift right, result bits enter at the MSB.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             step_d;
  logic             step_bout;
  logic             accept;
  logic             shift_en;
  logic             last_step;

  // The only arithmetic element: one bit of the subtraction per clock.
  full_subtractor u_fs (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Bin  (brw),
    .D    (step_d),
    .Bout (step_bout)
  );

  // Qualifiers shared by the FSM and the datapath; abort beats the terminal count.
  always_comb begin
    accept    = (state == IDLE) && start;
    shift_en  = (state == SHIFT) && !abort;
    last_step = shift_en && (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start wins over abort in IDLE, DONE always falls back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          next_state = IDLE;
        end else if (cnt == LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Status outputs are pure decodes of the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand capture on accept, then one shift per SHIFT cycle; an abort freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      brw   <= bin;
      cnt   <= '0;
    end else if (shift_en) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      d_sh  <= {step_d, d_sh[WIDTH-1:1]};
      brw   <= step_bout;
      cnt   <= cnt + ONE;
    end
  end

  // Visible result only changes on the final step, so it holds through IDLE and aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_step) begin
      diff <= {step_d, d_sh[WIDTH-1:1]};
      bout <= step_bout;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8 directed, WIDTH=4 exhaustive).
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, abort8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4, abort4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  typedef struct packed {logic [7:0] d; logic bo;} exp8_t;
  typedef struct packed {logic [3:0] d; logic bo;} exp4_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic bin; logic [7:0] d; logic bo;} vec_t;

  exp8_t q8[$];
  exp4_t q4[$];
  vec_t  tbl[6];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    model8 = {r[7:0], r[8]};
  endfunction

  // Scoreboard for the 8-bit instance: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      exp8_t e;
      if (q8.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_done8: got done=1 want no pending request");
      end else begin
        e = q8.pop_front();
        chk("diff8", {24'b0, diff8}, {24'b0, e.d});
        chk("bout8", {31'b0, bout8}, {31'b0, e.bo});
      end
    end
  end

  // Scoreboard for the 4-bit instance.
  always @(negedge clk) begin
    if (rst_n && done4) begin
      exp4_t e;
      if (q4.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_done4: got done=1 want no pending request");
      end else begin
        e = q4.pop_front();
        chk("diff4", {28'b0, diff4}, {28'b0, e.d});
        chk("bout4", {31'b0, bout4}, {31'b0, e.bo});
      end
    end
  end

  // Drive one request into the 8-bit instance (must be called while it is IDLE).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bin, input logic expect_done);
    a8 = a;
    b8 = b;
    bin8 = bin;
    start8 = 1'b1;
    if (expect_done) q8.push_back(model8(a, b, bin));
    tick;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input string name);
    int n;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    if (done8 !== 1'b1) begin
      nvec++;
      nmis++;
      $display("FAIL %s_timeout: got no done want done within 30 cycles", name);
    end
  endtask

  initial begin
    int dcnt;
    int dt[$];
    logic [8:0] v;
    logic [4:0] r5;
    int n;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1};
    tbl[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

    // Reset state.
    #3;
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_done", {31'b0, done8}, 32'd0);
    chk("rst_diff", {24'b0, diff8}, 32'd0);
    chk("rst_bout", {31'b0, bout8}, 32'd0);
    tick;
    rst_n = 1'b1;

    // Basic timing: busy after E0 through E8, done for one cycle after E8.
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{d: 8'h02, bo: 1'b0});
    tick;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("timing_busy", {31'b0, busy8}, 32'd1);
      chk("timing_nodone", {31'b0, done8}, 32'd0);
      tick;
    end
    chk("timing_done", {31'b0, done8}, 32'd1);
    chk("timing_busy_off", {31'b0, busy8}, 32'd0);
    tick;
    chk("timing_done_pulse", {31'b0, done8}, 32'd0);
    chk("timing_diff_hold", {24'b0, diff8}, 32'h02);

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      a8 = tbl[i].a; b8 = tbl[i].b; bin8 = tbl[i].bin; start8 = 1'b1;
      q8.push_back('{d: tbl[i].d, bo: tbl[i].bo});
      tick;
      start8 = 1'b0;
      wait_done8("tbl");
      tick;
    end

    // Borrow chain with operands scrambled while busy.
    a8 = 8'h10; b8 = 8'h0F; bin8 = 1'b1; start8 = 1'b1;
    q8.push_back('{d: 8'h00, bo: 1'b0});
    tick;
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 20) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      tick;
      n++;
    end
    wait_done8("scramble");
    tick;

    // start with abort in IDLE: start wins.
    abort8 = 1'b1;
    issue8(8'hA5, 8'h5A, 1'b0, 1'b1);
    abort8 = 1'b0;
    chk("start_beats_abort", {31'b0, busy8}, 32'd1);
    wait_done8("start_abort");
    tick;

    // start pulsed in SHIFT and in DONE is ignored.
    issue8(8'h77, 8'h12, 1'b1, 1'b1);
    tick; tick;
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    wait_done8("ignore");
    start8 = 1'b1;
    tick;
    start8 = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) dcnt++;
      tick;
    end
    chk("ignored_start_dones", dcnt, 32'd0);
    chk("ignored_start_idle", {31'b0, busy8}, 32'd0);

    // start held high: one operation every WIDTH+2 cycles.
    a8 = 8'h9C; b8 = 8'h3E; bin8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 3; i++) q8.push_back(model8(8'h9C, 8'h3E, 1'b0));
    for (int k = 1; k <= 35; k++) begin
      tick;
      if (k == 21) start8 = 1'b0;
      if (done8) dt.push_back(k);
    end
    chk("held_done_count", dt.size(), 32'd3);
    if (dt.size() == 3) begin
      chk("held_spacing0", dt[1] - dt[0], 32'd10);
      chk("held_spacing1", dt[2] - dt[1], 32'd10);
    end

    // Known prior result before the abort test.
    issue8(8'hFF, 8'h00, 1'b0, 1'b1);
    wait_done8("prior");
    tick;

    // Abort during the 4th SHIFT cycle: back to IDLE, result unchanged, no done.
    issue8(8'h33, 8'h11, 1'b0, 1'b0);
    tick; tick; tick;
    abort8 = 1'b1;
    tick;
    abort8 = 1'b0;
    chk("abort_idle", {31'b0, busy8}, 32'd0);
    chk("abort_diff", {24'b0, diff8}, 32'hFF);
    chk("abort_bout", {31'b0, bout8}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) dcnt++;
      tick;
    end
    chk("abort_no_done", dcnt, 32'd0);

    // Reset during the 3rd SHIFT cycle: outputs clear at once, no done afterwards.
    issue8(8'hC3, 8'h21, 1'b1, 1'b0);
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy8}, 32'd0);
    chk("midrst_done", {31'b0, done8}, 32'd0);
    chk("midrst_diff", {24'b0, diff8}, 32'd0);
    chk("midrst_bout", {31'b0, bout8}, 32'd0);
    tick;
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) dcnt++;
      tick;
    end
    chk("midrst_quiet", dcnt, 32'd0);

    // Exhaustive 4-bit sweep against the reference model.
    for (int x = 0; x < 512; x++) begin
      v = 9'(x);
      a4 = v[3:0]; b4 = v[7:4]; bin4 = v[8];
      r5 = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
      q4.push_back('{d: r5[3:0], bo: r5[4]});
      start4 = 1'b1;
      tick;
      start4 = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin
        tick;
        n++;
      end
      if (done4 !== 1'b1) begin
        nvec++;
        nmis++;
        $display("FAIL w4_timeout: got no done want done for vector %0d", x);
      end
      tick;
    end

    tick;
    chk("q8_drained", q8.size(), 32'd0);
    chk("q4_drained", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 Port: abort  input  1  synchronous cancel of an operation in progress.
REQ-006 Port: a  input  WIDTH  minuend; captured on the accepting start edge.
REQ-007 Port: b  input  WIDTH  subtrahend; captured on the accepting start edge.
REQ-008 Port: bin  input  1  borrow-in to bit 0; captured on the accepting start edge.
REQ-009 Port: busy  output  1  high while bit-serial subtraction is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  final borrow-out; 1 when a < b + bin.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at edge E0 -> load a, b and the borrow register (from bin), clear the bit counter, go to SHIFT.
REQ-015 SHIFT: each edge SHALL apply one full-subtractor step to a_reg[0], b_reg[0] and the borrow register, shift the difference bit into the diff shift register MSB, shift a_reg and b_reg right by 1, load the borrow register from the step's borrow-out, and increment the counter.
REQ-016 After exactly WIDTH SHIFT edges (E1..E_WIDTH) the FSM SHALL go to DONE; diff and bout SHALL then hold the complete result.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-018 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both are registered-state decodes with no combinational path from inputs.
REQ-019 start SHALL be ignored in SHIFT and DONE; back-to-back requests are accepted no earlier than the first IDLE cycle after DONE.
REQ-020 diff and bout SHALL hold the last completed result through IDLE until the next DONE; intermediate shifting SHALL occur in internal registers only.
REQ-021 abort=1 in SHIFT SHALL return the FSM to IDLE at the next edge; no done pulse; diff and bout keep their previous values; abort has priority over counter terminal count.
REQ-022 abort in IDLE or DONE SHALL have no effect; start and abort both high in IDLE -> start wins.
REQ-023 Counter width SHALL be $clog2(WIDTH+1); the terminal compare is count == WIDTH-1 during SHIFT.
REQ-024 Operand changes on a, b and bin after acceptance SHALL NOT affect the result in progress.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, and all internal operand and borrow registers to 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation; after release, no done pulse is produced until a new start.
REQ-027 Deassertion of rst_n is synchronous to clk, guaranteed externally; the first start is accepted on the first edge with rst_n high.

Structure
REQ-028 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined as constants in the shared package serial_sub_pkg.
REQ-029 The per-bit step SHALL instantiate the team's existing full_subtractor cell (ports A, B, Bin, D, Bout) once; no other sub-module.
REQ-030 The implementation SHALL contain no adder or subtract operator on the operands; all arithmetic goes through the instantiated cell.

Verification
REQ-031 WIDTH=8, a=8'h05, b=8'h03, bin=0, start at E0 -> busy high after E0 through E8, done for one cycle after E8, diff=8'h02, bout=0.
REQ-032 Underflow: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; a=8'h00, b=8'hFF, bin=1 -> diff=8'h00, bout=1.
REQ-033 Borrow chain: a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0; a, b and bin are toggled randomly while busy, and the result SHALL be unchanged.
REQ-034 start pulsed during SHIFT and during DONE -> ignored, with exactly one done per accepted request; start held high continuously -> a new operation every WIDTH+2 cycles.
REQ-035 abort at the 4th SHIFT cycle -> IDLE next edge, no done, diff and bout equal the prior result; rst_n low at the 3rd SHIFT cycle -> all outputs 0 immediately, and no done after release.
REQ-036 Exhaustive check with WIDTH=4: all 512 (a, b, bin) combinations checked against the reference model (a-b-bin) mod 16 and the borrow.
